// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions: register-file geometry, destination-mux select encodings
// and the two-port write-back arbitration rule.
package wb_port_arbiter_pkg;

  localparam int unsigned RegNumW = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned WaitW   = 4;

  // Destination mux select encodings, shared with the register-file write path.
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_LL  = 1'b1;

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntLl
  } grant_e;

  // The ALU wins by default. The long-latency unit wins when it has been starved for too
  // long, or when both target the same register, so that the older result lands first.
  function automatic grant_e arb_pick(input logic v_alu, input logic v_ll,
                                      input logic same_dst, input logic starved);
    grant_e g;
    g = GntNone;
    if (v_alu && v_ll) begin
      g = (same_dst || starved) ? GntLl : GntAlu;
    end else if (v_alu) begin
      g = GntAlu;
    end else if (v_ll) begin
      g = GntLl;
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Register-file write-back arbiter between the ALU port (req0) and the long-latency port
// (req1). Grants are combinational; the accepted request is written one cycle later.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               v0,
  input  logic [RegNumW-1:0] rn0,
  input  logic [DataW-1:0]   d0,
  output logic               rdy0,
  input  logic               v1,
  input  logic [RegNumW-1:0] rn1,
  input  logic [DataW-1:0]   d1,
  output logic               rdy1,
  output logic               wen,
  output logic [RegNumW-1:0] wn,
  output logic [DataW-1:0]   wd,
  output logic               sel,
  output logic               stall0
);

  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  logic               wen_d, wen_q;
  logic [RegNumW-1:0] wn_d, wn_q;
  logic [DataW-1:0]   wd_d, wd_q;
  logic               sel_d, sel_q;
  logic [WaitW-1:0]   wait_cnt_d, wait_cnt_q;

  grant_e grant;
  logic   grant0;
  logic   grant1;

  always_comb begin
    grant = GntNone;
    // Nothing is accepted while reset is held, so a request cannot slip past reset.
    if (clrn) begin
      grant = arb_pick(v0, v1, rn0 == rn1, wait_cnt_q >= MaxWait);
    end
    grant0 = (grant == GntAlu);
    grant1 = (grant == GntLl);
  end

  always_comb begin
    wen_d      = 1'b0;
    wn_d       = wn_q;
    wd_d       = wd_q;
    sel_d      = sel_q;
    wait_cnt_d = '0;

    unique case (grant)
      GntAlu: begin
        wn_d  = rn0;
        wd_d  = d0;
        sel_d = SEL_ALU;
        wen_d = (rn0 != '0);
      end
      GntLl: begin
        wn_d  = rn1;
        wd_d  = d1;
        sel_d = SEL_LL;
        wen_d = (rn1 != '0);
      end
      default: ;
    endcase

    if (v1 && !grant1) begin
      wait_cnt_d = (wait_cnt_q >= MaxWait) ? MaxWait : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wen_q      <= 1'b0;
      wn_q       <= '0;
      wd_q       <= '0;
      sel_q      <= SEL_ALU;
      wait_cnt_q <= '0;
    end else begin
      wen_q      <= wen_d;
      wn_q       <= wn_d;
      wd_q       <= wd_d;
      sel_q      <= sel_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign rdy0   = grant0;
  assign rdy1   = grant1;
  assign stall0 = v0 & ~grant0;
  assign wen    = wen_q;
  assign wn     = wn_q;
  assign wd     = wd_q;
  assign sel    = sel_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

  localparam int MaxWait = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        v0, v1;
  logic [4:0]  rn0, rn1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, wen, sel, stall0;
  logic [4:0]  wn;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state: the pending write and the denial streak of port 1.
  bit        m_wen;
  bit [4:0]  m_wn;
  bit [31:0] m_wd;
  bit        m_sel;
  int        m_wait;

  logic [31:0] rf [32];

  wb_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .v0    (v0),
    .rn0   (rn0),
    .d0    (d0),
    .rdy0  (rdy0),
    .v1    (v1),
    .rn1   (rn1),
    .d1    (d1),
    .rdy1  (rdy1),
    .wen   (wen),
    .wn    (wn),
    .wd    (wd),
    .sel   (sel),
    .stall0(stall0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = no grant, 1 = port 0, 2 = port 1.
  function automatic int exp_grant(input bit rst_n, input bit a, input bit b,
                                   input bit [4:0] r0, input bit [4:0] r1, input int w);
    if (!rst_n) return 0;
    if (a && b) return (r0 == r1 || w >= MaxWait) ? 2 : 1;
    if (a) return 1;
    if (b) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant(clrn, v0, v1, rn0, rn1, m_wait);
    if (!clrn) begin
      m_wen = 0; m_wn = 0; m_wd = 0; m_sel = 0; m_wait = 0;
    end else begin
      if (g == 1) begin
        m_wn = rn0; m_wd = d0; m_sel = 0; m_wen = (rn0 != 0);
      end else if (g == 2) begin
        m_wn = rn1; m_wd = d1; m_sel = 1; m_wen = (rn1 != 0);
      end else begin
        m_wen = 0;
      end
      m_wait = (v1 && g != 2) ? ((m_wait + 1 > MaxWait) ? MaxWait : m_wait + 1) : 0;
    end
  end

  always @(negedge clk) begin
    int g;
    if (check_en) begin
      g = exp_grant(clrn, v0, v1, rn0, rn1, m_wait);
      chk("model rdy0", 32'(rdy0), 32'(g == 1));
      chk("model rdy1", 32'(rdy1), 32'(g == 2));
      chk("model stall0", 32'(stall0), 32'(v0 && g != 1));
      chk("model wen", 32'(wen), 32'(m_wen));
      chk("model wn", 32'(wn), 32'(m_wn));
      chk("model wd", wd, m_wd);
      chk("model sel", 32'(sel), 32'(m_sel));
    end
  end

  // Register file as seen through the DUT write port.
  always @(negedge clk) begin
    if (wen === 1'b1) rf[wn] = wd;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wen_run;
    clrn = 0; v0 = 1; v1 = 1; rn0 = 3; rn1 = 4; d0 = 32'h1; d1 = 32'h2;
    next();
    check_en = 1;
    neg();
    chk("reset rdy0", 32'(rdy0), 0);
    chk("reset rdy1", 32'(rdy1), 0);
    chk("reset wen", 32'(wen), 0);
    chk("reset wn", 32'(wn), 0);
    chk("reset wd", wd, 0);
    chk("reset sel", 32'(sel), 0);

    // Lone ALU request.
    next(); clrn = 1; v0 = 1; rn0 = 5; d0 = 32'h11; v1 = 0;
    neg(); chk("alone rdy0", 32'(rdy0), 1);
    next(); v0 = 0;
    neg();
    chk("alone wen", 32'(wen), 1);
    chk("alone wn", 32'(wn), 5);
    chk("alone wd", wd, 32'h11);
    chk("alone sel", 32'(sel), 0);

    // Starvation override after MaxWait denials.
    next(); v0 = 1; v1 = 1; rn0 = 3; rn1 = 7; d0 = 32'h30; d1 = 32'h70;
    for (int c = 1; c <= 6; c++) begin
      neg();
      chk("starve rdy0", 32'(rdy0), 32'(c != 5));
      chk("starve rdy1", 32'(rdy1), 32'(c == 5));
      next();
    end

    // Same destination: the older long-latency result goes first.
    rn0 = 9; rn1 = 9; d0 = 32'hA; d1 = 32'hB;
    neg();
    chk("same rdy1", 32'(rdy1), 1);
    chk("same rdy0", 32'(rdy0), 0);
    next(); v1 = 0;
    neg();
    chk("same first wd", wd, 32'hB);
    chk("same first sel", 32'(sel), 1);
    chk("same then rdy0", 32'(rdy0), 1);
    next(); v0 = 0;
    neg();
    chk("same second wd", wd, 32'hA);
    chk("same second sel", 32'(sel), 0);
    #1 chk("same final reg9", rf[9], 32'hA);

    // Destination 0 is accepted but not written.
    next(); v1 = 1; rn1 = 0; d1 = 32'h33;
    neg(); chk("r0 rdy1", 32'(rdy1), 1);
    next(); v1 = 0;
    neg();
    chk("r0 wen", 32'(wen), 0);
    chk("r0 wd", wd, 32'h33);

    // Reset mid-stream.
    next(); v0 = 1; v1 = 1; rn0 = 1; rn1 = 2;
    neg();
    next(); clrn = 0;
    neg();
    chk("rst rdy0", 32'(rdy0), 0);
    chk("rst rdy1", 32'(rdy1), 0);
    next();
    neg();
    chk("rst wen", 32'(wen), 0);
    chk("rst wn", 32'(wn), 0);
    chk("rst wd", wd, 0);
    chk("rst sel", 32'(sel), 0);
    next(); clrn = 1;
    neg(); chk("rst resume rdy0", 32'(rdy0), 1);

    // Alternating single requests: one write per cycle, no bubble.
    wen_run = 0;
    for (int i = 0; i <= 16; i++) begin
      next();
      v0 = (i < 16) && (i % 2 == 0);
      v1 = (i < 16) && (i % 2 == 1);
      rn0 = 5'(i + 1); rn1 = 5'(i + 1); d0 = 32'(i); d1 = 32'(i + 100);
      neg();
      if (i > 0 && wen === 1'b1) wen_run++;
    end
    chk("no bubble wen count", 32'(wen_run), 16);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      next();
      clrn = ($urandom_range(0, 59) != 0);
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 2) != 0);
      rn0  = 5'($urandom_range(0, 7));
      rn1  = 5'($urandom_range(0, 7));
      d0   = $urandom;
      d1   = $urandom;
    end
    next();
    v0 = 0; v1 = 0;
    neg();
    #1;
    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
